// File: rtl/matrixmult_pkg.sv
// Shared types and constants for the matrixmult feeder slice.
// State encoding, dimensions and beat count used by feeder and coefficient file.
package matrixmult_pkg;

    localparam int unsigned MM_DIM     = 4;
    localparam int unsigned MM_FLOAT_W = 32;
    localparam int unsigned MM_BEATS   = 16;
    localparam int unsigned MM_ADDR_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STREAM    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_HOLD      = 2'd3
    } mm_state_e;

endpackage

// File: rtl/matrixmult_coeff_regs.sv
// 16 x 32 coefficient register file, one synchronous write port and
// one combinational read port addressed by the beat counter.
module matrixmult_coeff_regs
    import matrixmult_pkg::*;
#(
    parameter int unsigned DATA_W = MM_FLOAT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [MM_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [MM_ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [MM_BEATS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MM_BEATS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/matrixmult_feeder.sv
// Sequencing front end for matrixmultiplier: streams 16 operand beats, captures results.
// Optional WAIT_DONE watchdog enabled by defining MATRIXMULT_FEEDER_TIMEOUT_EN.
module matrixmult_feeder
    import matrixmult_pkg::*;
#(
    parameter int unsigned DATA_W         = MM_FLOAT_W,
    parameter int unsigned DIM            = MM_DIM,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    coef_we,
    input  logic [MM_ADDR_W-1:0]    coef_addr,
    input  logic [DATA_W-1:0]       coef_wdata,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [DIM*DATA_W-1:0]   pix_data,
    output logic [DATA_W-1:0]       a,
    output logic [DATA_W-1:0]       b,
    output logic                    a_tvalid,
    output logic                    b_tvalid,
    input  logic                    done_matrixmult,
    input  logic [DATA_W-1:0]       result0,
    input  logic [DATA_W-1:0]       result1,
    input  logic [DATA_W-1:0]       result2,
    input  logic [DATA_W-1:0]       result3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIM*DATA_W-1:0]   out_data,
    output logic                    busy,
    output logic                    error
);

    if (DIM != MM_DIM || TIMEOUT_CYCLES == 0) begin : g_cfg_unsupported
    end

    mm_state_e                   state_q;
    logic [MM_ADDR_W-1:0]        cnt_q;
    logic [DIM-1:0][DATA_W-1:0]  pix_q;
    logic [DATA_W-1:0]           a_q;
    logic [DATA_W-1:0]           b_q;
    logic                        tvalid_q;
    logic                        pix_ready_q;
    logic                        out_valid_q;
    logic [DIM*DATA_W-1:0]       out_data_q;
    logic                        busy_q;

    logic                        coef_wen_d;
    logic [DATA_W-1:0]           coef_rd;
    logic [DATA_W-1:0]           beat0_coef_d;

    assign coef_wen_d = coef_we && (state_q != S_STREAM);

    matrixmult_coeff_regs #(
        .DATA_W (DATA_W)
    ) u_coeff_regs (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (coef_wen_d),
        .waddr_i (coef_addr),
        .wdata_i (coef_wdata),
        .raddr_i (cnt_q),
        .rdata_o (coef_rd)
    );

    // Beat 0 is registered on the accept edge, so a same-cycle write to
    // address 0 must be forwarded around the register file.
    assign beat0_coef_d = (coef_we && coef_addr == '0) ? coef_wdata : coef_rd;

`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] tcnt_q;
    logic            error_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pix_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tvalid_q    <= 1'b0;
            pix_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
            tcnt_q      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pix_valid) begin
                        pix_q       <= pix_data;
                        a_q         <= beat0_coef_d;
                        b_q         <= pix_data[DATA_W-1:0];
                        tvalid_q    <= 1'b1;
                        cnt_q       <= MM_ADDR_W'(1);
                        pix_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    a_q   <= coef_rd;
                    b_q   <= pix_q[cnt_q[1:0]];
                    cnt_q <= cnt_q + MM_ADDR_W'(1);
                    if (cnt_q == MM_ADDR_W'(MM_BEATS - 1)) begin
                        state_q <= S_WAIT_DONE;
`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
                        tcnt_q  <= '0;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    tvalid_q <= 1'b0;
                    if (done_matrixmult) begin
                        out_data_q  <= {result3, result2, result1, result0};
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
                    else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        error_q     <= 1'b1;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TO_W'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_ready = pix_ready_q;
    assign a         = a_q;
    assign b         = b_q;
    assign a_tvalid  = tvalid_q;
    assign b_tvalid  = tvalid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_matrixmult_feeder.sv
// Self-checking bench for matrixmult_feeder with a behavioural reference model.
// Timeout scenario is exercised when MATRIXMULT_FEEDER_TIMEOUT_EN is defined.
module tb_matrixmult_feeder;

    logic         clk = 1'b0;
    logic         reset;
    logic         coef_we;
    logic [3:0]   coef_addr;
    logic [31:0]  coef_wdata;
    logic         pix_valid;
    logic         pix_ready;
    logic [127:0] pix_data;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         a_tvalid;
    logic         b_tvalid;
    logic         done_matrixmult;
    logic [31:0]  result0;
    logic [31:0]  result1;
    logic [31:0]  result2;
    logic [31:0]  result3;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         error;

    int tests = 0;
    int fails = 0;

    logic [31:0] cm [16];
    logic [31:0] obs_a [16];
    logic [31:0] obs_b [16];
    int          obs_n;
    int          obs_tv_bad;

    always #5 clk = ~clk;

    matrixmult_feeder dut (
        .clk             (clk),
        .reset           (reset),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_wdata      (coef_wdata),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_data        (pix_data),
        .a               (a),
        .b               (b),
        .a_tvalid        (a_tvalid),
        .b_tvalid        (b_tvalid),
        .done_matrixmult (done_matrixmult),
        .result0         (result0),
        .result1         (result1),
        .result2         (result2),
        .result3         (result3),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .busy            (busy),
        .error           (error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [3:0] ad, input logic [31:0] d);
        coef_we = 1'b1; coef_addr = ad; coef_wdata = d;
        step();
        coef_we = 1'b0;
        cm[ad] = d;
    endtask

    task automatic load_model_matrix();
        for (int i = 0; i < 16; i++) write_coef(4'(i), cm[i]);
    endtask

    task automatic pulse_done(input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3);
        result0 = r0; result1 = r1; result2 = r2; result3 = r3;
        done_matrixmult = 1'b1;
        step();
        done_matrixmult = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic drain_stream();
        for (int c = 0; c < 40; c++) begin
            if (a_tvalid !== 1'b1) break;
            step();
        end
    endtask

    task automatic collect_stream(input logic [127:0] pix);
        obs_n = 0; obs_tv_bad = 0;
        pix_data = pix; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (a_tvalid !== b_tvalid) obs_tv_bad++;
            if (a_tvalid !== 1'b1) break;
            if (obs_n < 16) begin
                obs_a[obs_n] = a;
                obs_b[obs_n] = b;
            end
            obs_n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        tests++;
        if ({pix_ready, a_tvalid, b_tvalid, out_valid, busy, error} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 100000",
                     {pix_ready, a_tvalid, b_tvalid, out_valid, busy, error});
        end
        tests++;
        if ({a, b, out_data} !== 192'd0) begin
            fails++;
            $display("FAIL reset_data: got a=%h b=%h out=%h want zeros", a, b, out_data);
        end
    endtask

    task automatic test_stream_order();
        logic [127:0] pix;
        logic [31:0]  ea;
        logic [31:0]  eb;
        int           bad;
        cm = '{32'h4124CCCD, 32'h40C80000, 32'h40A9999A, 32'h3C4CCCCD,
               32'h40400000, 32'h40980000, 32'h3F000000, 32'h41200000,
               32'h3E800000, 32'hBF800000, 32'h42C80000, 32'h3DCCCCCD,
               32'h40E00000, 32'h41880000, 32'hC0400000, 32'h3F400000};
        load_model_matrix();
        pix = {32'h4040A3D7, 32'hC1691EB8, 32'h4141999A, 32'hBF07AE14};
        collect_stream(pix);
        tests++;
        if (obs_n !== 16 || obs_tv_bad !== 0) begin
            fails++;
            $display("FAIL stream_len: got %0d beats (tvalid skew %0d) want 16", obs_n, obs_tv_bad);
        end
        tests++;
        if (obs_a[0] !== 32'h4124CCCD || obs_b[0] !== 32'hBF07AE14) begin
            fails++;
            $display("FAIL beat0: got a=%h b=%h want 4124cccd bf07ae14", obs_a[0], obs_b[0]);
        end
        tests++;
        if (obs_a[5] !== 32'h40980000 || obs_b[5] !== 32'h4141999A) begin
            fails++;
            $display("FAIL beat5: got a=%h b=%h want 40980000 4141999a", obs_a[5], obs_b[5]);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            ea = cm[i];
            eb = pix[32*(i%4) +: 32];
            if (obs_a[i] !== ea || obs_b[i] !== eb) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stream_order: %0d beats wrong want 0", bad);
        end
        tests++;
        if (a !== cm[15] || b !== pix[127:96] || busy !== 1'b1) begin
            fails++;
            $display("FAIL wait_hold_ab: got a=%h b=%h busy=%b want %h %h 1",
                     a, b, busy, cm[15], pix[127:96]);
        end
        pulse_done('0, '0, '0, '0);
        handshake();
    endtask

    task automatic test_result_capture();
        logic [127:0] exp;
        int           bad;
        pulse_done(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tests++;
        if (out_valid !== 1'b0 || out_data !== 128'd0) begin
            fails++;
            $display("FAIL done_in_idle: got valid=%b data=%h want 0 0", out_valid, out_data);
        end
        collect_stream({4{32'h3F800000}});
        pulse_done(32'hC0E08E56, 32'h43BBB7CF, 32'h43B80498, 32'h4082161E);
        exp = {32'h4082161E, 32'h43B80498, 32'h43BBB7CF, 32'hC0E08E56};
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            fails++;
            $display("FAIL capture: got valid=%b data=%h want 1 %h", out_valid, out_data, exp);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== exp || pix_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: %0d unstable cycles want 0", bad);
        end
        handshake();
        tests++;
        if ({out_valid, pix_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL release: got %b want 010", {out_valid, pix_ready, busy});
        end
    endtask

    task automatic test_write_lockout();
        pix_data = {4{32'h40000000}}; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        step(); step(); step();
        tests++;
        if (a_tvalid !== 1'b1 || a !== cm[3]) begin
            fails++;
            $display("FAIL beat3_seen: got tv=%b a=%h want 1 %h", a_tvalid, a, cm[3]);
        end
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 32'h3F800000;
        step();
        coef_we = 1'b0;
        drain_stream();
        pulse_done('0, '0, '0, '0);
        handshake();
        collect_stream({4{32'h40000000}});
        tests++;
        if (obs_n !== 16 || obs_a[0] !== 32'h4124CCCD) begin
            fails++;
            $display("FAIL lockout: got beats=%0d a0=%h want 16 4124cccd", obs_n, obs_a[0]);
        end
        pulse_done('0, '0, '0, '0);
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [127:0] v1;
        logic [127:0] v2;
        int           bad;
        v1 = {32'h1, 32'h2, 32'h3, 32'h4};
        v2 = {32'hA, 32'hB, 32'hC, 32'hD};
        pix_data = v1; pix_valid = 1'b1;
        step();
        pix_data = v2;
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (pix_ready !== 1'b0) bad++;
            step();
        end
        pulse_done(32'h5, 32'h6, 32'h7, 32'h8);
        for (int i = 0; i < 2; i++) begin
            if (pix_ready !== 1'b0) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure: pix_ready high %0d cycles want 0", bad);
        end
        handshake();
        tests++;
        if ({pix_ready, a_tvalid, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL no_same_cycle: got %b want 100", {pix_ready, a_tvalid, out_valid});
        end
        step();
        pix_valid = 1'b0;
        tests++;
        if (a_tvalid !== 1'b1 || pix_ready !== 1'b0 || b !== 32'hD || a !== cm[0]) begin
            fails++;
            $display("FAIL second_accept: got tv=%b rdy=%b a=%h b=%h want 1 0 %h 0000000d",
                     a_tvalid, pix_ready, a, b, cm[0]);
        end
        drain_stream();
        pulse_done('0, '0, '0, '0);
        handshake();
    endtask

    task automatic test_same_cycle_write();
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 32'hDEADBEEF;
        pix_data = {4{32'h12345678}}; pix_valid = 1'b1;
        step();
        coef_we = 1'b0; pix_valid = 1'b0;
        cm[0] = 32'hDEADBEEF;
        tests++;
        if (a_tvalid !== 1'b1 || a !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL same_cycle_write: got tv=%b a=%h want 1 deadbeef", a_tvalid, a);
        end
        drain_stream();
        pulse_done('0, '0, '0, '0);
        handshake();
    endtask

    task automatic test_reset_midstream();
        pix_data = {4{32'h0F0F0F0F}}; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        tests++;
        if (a_tvalid !== 1'b1 || a !== cm[7]) begin
            fails++;
            $display("FAIL beat7_seen: got tv=%b a=%h want 1 %h", a_tvalid, a, cm[7]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({a_tvalid, b_tvalid, busy, out_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL async_abort: got %b want 0000", {a_tvalid, b_tvalid, busy, out_valid});
        end
        step();
        reset = 1'b1;
        step();
        tests++;
        if ({pix_ready, busy, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL after_reset: got %b want 100", {pix_ready, busy, out_valid});
        end
        for (int i = 0; i < 16; i++) cm[i] = '0;
        collect_stream({4{32'h77777777}});
        tests++;
        if (obs_n !== 16 || obs_a[0] !== 32'd0 || obs_a[9] !== 32'd0) begin
            fails++;
            $display("FAIL coef_cleared: got beats=%0d a0=%h a9=%h want 16 0 0",
                     obs_n, obs_a[0], obs_a[9]);
        end
        pulse_done('0, '0, '0, '0);
        handshake();
    endtask

    task automatic test_random();
        logic [127:0] pix;
        logic [127:0] exp;
        logic [31:0]  r [4];
        int           bad;
        int           nwrite;
        for (int t = 0; t < 6; t++) begin
            nwrite = (t == 0) ? 16 : int'($urandom_range(1, 6));
            for (int k = 0; k < nwrite; k++) begin
                write_coef((t == 0) ? 4'(k) : 4'($urandom_range(0, 15)), $urandom);
            end
            pix = {$urandom, $urandom, $urandom, $urandom};
            collect_stream(pix);
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (obs_a[i] !== cm[i] || obs_b[i] !== pix[32*(i%4) +: 32]) bad++;
            end
            tests++;
            if (obs_n !== 16 || obs_tv_bad !== 0 || bad != 0) begin
                fails++;
                $display("FAIL rand_stream[%0d]: beats=%0d skew=%0d wrong=%0d want 16 0 0",
                         t, obs_n, obs_tv_bad, bad);
            end
            write_coef(4'($urandom_range(0, 15)), $urandom);
            for (int d = 0; d < int'($urandom_range(0, 4)); d++) step();
            for (int i = 0; i < 4; i++) r[i] = $urandom;
            pulse_done(r[0], r[1], r[2], r[3]);
            exp = {r[3], r[2], r[1], r[0]};
            bad = 0;
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                result0 = $urandom; result1 = $urandom;
                done_matrixmult = 1'b1;
                step();
                done_matrixmult = 1'b0;
                if (out_valid !== 1'b1 || out_data !== exp) bad++;
            end
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp || bad != 0) begin
                fails++;
                $display("FAIL rand_result[%0d]: got %b %h want 1 %h", t, out_valid, out_data, exp);
            end
            handshake();
        end
    endtask

`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        int seen_valid;
        int waited;
        collect_stream({4{32'h5A5A5A5A}});
        seen_valid = 0;
        waited = 0;
        for (int c = 0; c < 200; c++) begin
            if (out_valid === 1'b1) seen_valid++;
            if (busy !== 1'b1) break;
            waited++;
            step();
        end
        tests++;
        if (error !== 1'b1 || pix_ready !== 1'b1 || seen_valid != 0 || waited != 63) begin
            fails++;
            $display("FAIL timeout: err=%b rdy=%b valid_seen=%0d waited=%0d want 1 1 0 63",
                     error, pix_ready, seen_valid, waited);
        end
        handshake();
        step();
        tests++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL error_sticky: got %b want 1", error);
        end
    endtask
`endif

    initial begin
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        pix_valid = 1'b0; pix_data = '0;
        done_matrixmult = 1'b0;
        result0 = '0; result1 = '0; result2 = '0; result3 = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) cm[i] = '0;
        test_reset();
        test_stream_order();
        test_result_capture();
        test_write_lockout();
        test_back_to_back();
        test_same_cycle_write();
        test_reset_midstream();
        test_random();
`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
